// File: rtl/tank_sprite_pkg.sv
// Shared types and sizing for the bullet sprite renderer.
// The ROM address is {dir, ly, lx}, so its width follows from the sprite edge.
package tank_sprite_pkg;

  localparam int SPR_DIM = 8;
  localparam int SPR_LOG = $clog2(SPR_DIM);
  localparam int ROM_AW  = 2 + 2 * SPR_LOG;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  typedef struct packed {
    logic       active;
    logic [9:0] x;
    logic [9:0] y;
    dir_e       dir;
  } bullet_slot_t;

endpackage

// File: rtl/bullet_hit_test.sv
// Per-slot coverage test: does the current pixel fall inside this bullet's sprite box?
// The subtraction is one bit wider than the coordinates so that a pixel left of or above the box borrows instead of wrapping.
module bullet_hit_test
  import tank_sprite_pkg::*;
(
  input  bullet_slot_t       slot_i,
  input  logic [9:0]         draw_x_i,
  input  logic [9:0]         draw_y_i,
  input  logic               blank_i,
  output logic               covered_o,
  output logic [SPR_LOG-1:0] lx_o,
  output logic [SPR_LOG-1:0] ly_o
);

  logic [10:0] dx;
  logic [10:0] dy;

  assign dx = {1'b0, draw_x_i} - {1'b0, slot_i.x};
  assign dy = {1'b0, draw_y_i} - {1'b0, slot_i.y};

  assign covered_o = slot_i.active & blank_i
                   & ~dx[10] & (dx < 11'(SPR_DIM))
                   & ~dy[10] & (dy < 11'(SPR_DIM));

  assign lx_o = dx[SPR_LOG-1:0];
  assign ly_o = dy[SPR_LOG-1:0];

endmodule

// File: rtl/bullet_render_sched.sv
// Shares one bullet sprite ROM among NUM_BULLETS slots. Game logic writes a shadow bank, which is copied to the display bank at frame start.
// Each pixel gives a registered hit/slot three cycles after DrawX/DrawY, one pixel per cycle.
module bullet_render_sched
  import tank_sprite_pkg::*;
#(
  parameter  int NUM_BULLETS = 4,
  localparam int SW          = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [SW-1:0]     upd_slot,
  input  logic [9:0]        upd_x,
  input  logic [9:0]        upd_y,
  input  logic [1:0]        upd_dir,
  input  logic              upd_active,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic              rom_q,
  output logic              bullet_hit,
  output logic [SW-1:0]     hit_slot
);

  bullet_slot_t shadow_q [NUM_BULLETS];
  bullet_slot_t disp_q   [NUM_BULLETS];

  // Updates stall during the swap cycle so that the copy sees a stable shadow bank.
  assign upd_ready = ~reset & ~frame_start;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BULLETS; i++) begin
        shadow_q[i] <= '0;
        disp_q[i]   <= '0;
      end
    end else begin
      if (upd_valid && upd_ready) begin
        shadow_q[upd_slot] <= '{active: upd_active, x: upd_x, y: upd_y,
                                dir: dir_e'(upd_dir)};
      end
      if (frame_start) begin
        disp_q <= shadow_q;
      end
    end
  end

  logic [NUM_BULLETS-1:0] covered;
  logic [SPR_LOG-1:0]     lx [NUM_BULLETS];
  logic [SPR_LOG-1:0]     ly [NUM_BULLETS];

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_hit
    bullet_hit_test u_hit (
      .slot_i   (disp_q[g]),
      .draw_x_i (DrawX),
      .draw_y_i (DrawY),
      .blank_i  (blank),
      .covered_o(covered[g]),
      .lx_o     (lx[g]),
      .ly_o     (ly[g])
    );
  end

  logic              win_valid;
  logic [SW-1:0]     win_slot;
  logic [ROM_AW-1:0] win_addr;

  // Scan downwards so the lowest covered index overwrites the others; a transparent winner still masks lower-priority slots.
  always_comb begin
    win_valid = 1'b0;
    win_slot  = '0;
    win_addr  = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (covered[i]) begin
        win_valid = 1'b1;
        win_slot  = SW'(i);
        win_addr  = {disp_q[i].dir, ly[i], lx[i]};
      end
    end
  end

  logic [ROM_AW-1:0] rom_addr_q;
  logic              sel_valid_q, sel_valid_s2_q;
  logic [SW-1:0]     sel_slot_q, sel_slot_s2_q;
  logic              hit_d, hit_q;
  logic [SW-1:0]     hit_slot_d, hit_slot_q;

  assign hit_d      = sel_valid_s2_q & rom_q;
  assign hit_slot_d = hit_d ? sel_slot_s2_q : '0;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rom_addr_q     <= '0;
      sel_valid_q    <= 1'b0;
      sel_slot_q     <= '0;
      sel_valid_s2_q <= 1'b0;
      sel_slot_s2_q  <= '0;
      hit_q          <= 1'b0;
      hit_slot_q     <= '0;
    end else begin
      rom_addr_q     <= win_addr;
      sel_valid_q    <= win_valid;
      sel_slot_q     <= win_slot;
      sel_valid_s2_q <= sel_valid_q;
      sel_slot_s2_q  <= sel_slot_q;
      hit_q          <= hit_d;
      hit_slot_q     <= hit_slot_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign bullet_hit = hit_q;
  assign hit_slot   = hit_slot_q;

endmodule

// File: tb/tb_bullet_render_sched.sv
// Scoreboard bench for bullet_render_sched: each pixel pushes the expected rom_addr (due one cycle later) and the expected hit/slot (due three cycles later).
module tb_bullet_render_sched;
  import tank_sprite_pkg::*;

  logic       vga_clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic       upd_valid = 1'b0;
  logic       upd_ready;
  logic [1:0] upd_slot = '0;
  logic [9:0] upd_x = '0, upd_y = '0;
  logic [1:0] upd_dir = '0;
  logic       upd_active = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0;
  logic       blank = 1'b0;
  logic [7:0] rom_addr;
  logic       rom_q = 1'b0;
  logic       bullet_hit;
  logic [1:0] hit_slot;

  bullet_render_sched #(.NUM_BULLETS(4)) dut (
    .vga_clk(vga_clk), .reset(reset), .frame_start(frame_start),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_slot(upd_slot),
    .upd_x(upd_x), .upd_y(upd_y), .upd_dir(upd_dir), .upd_active(upd_active),
    .DrawX(DrawX), .DrawY(DrawY), .blank(blank), .rom_addr(rom_addr),
    .rom_q(rom_q), .bullet_hit(bullet_hit), .hit_slot(hit_slot)
  );

  always #5 vga_clk = ~vga_clk;

  // Synchronous sprite ROM: data appears one cycle after the address.
  logic rom_mem [256];
  always @(posedge vga_clk) rom_q <= rom_mem[rom_addr];

  bullet_slot_t m_shadow [4];
  bullet_slot_t m_disp   [4];

  typedef struct {int due; logic [7:0] addr;} aexp_t;
  typedef struct {int due; logic hit; logic [1:0] slot;} hexp_t;
  aexp_t aq[$];
  hexp_t hq[$];
  aexp_t ae;
  hexp_t he;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  function automatic void model(input int px, input int py, input logic b,
                                output logic [7:0] a, output logic h, output logic [1:0] s);
    a = '0; h = 1'b0; s = '0;
    if (b) begin
      for (int i = 0; i < 4; i++) begin
        int bx, by;
        bx = int'(m_disp[i].x);
        by = int'(m_disp[i].y);
        if (m_disp[i].active && px >= bx && px < bx + 8 && py >= by && py < by + 8) begin
          a = 8'(int'(m_disp[i].dir) * 64 + (py - by) * 8 + (px - bx));
          h = rom_mem[a];
          s = h ? 2'(i) : 2'd0;
          break;
        end
      end
    end
  endfunction

  always @(posedge vga_clk) begin
    cyc = cyc + 1;
    #1;
    while (aq.size() > 0 && aq[0].due <= cyc) begin
      ae = aq.pop_front();
      n_checks++;
      if (rom_addr !== ae.addr) begin
        n_fail++;
        $display("FAIL rom_addr cyc=%0d got=%h exp=%h", cyc, rom_addr, ae.addr);
      end
    end
    while (hq.size() > 0 && hq[0].due <= cyc) begin
      he = hq.pop_front();
      n_checks++;
      if (bullet_hit !== he.hit || hit_slot !== he.slot) begin
        n_fail++;
        $display("FAIL hit cyc=%0d got=%b/%0d exp=%b/%0d", cyc, bullet_hit, hit_slot, he.hit, he.slot);
      end
    end
  end

  task automatic pix(input int px, input int py, input logic b);
    logic [7:0] a;
    logic h;
    logic [1:0] s;
    @(negedge vga_clk);
    DrawX = 10'(px);
    DrawY = 10'(py);
    blank = b;
    model(px, py, b, a, h, s);
    aq.push_back('{cyc + 1, a});
    hq.push_back('{cyc + 3, h, s});
  endtask

  task automatic write_slot(input int sl, input int x, input int y, input int d, input logic act);
    int tries;
    tries = 0;
    @(negedge vga_clk);
    upd_valid = 1'b1;
    upd_slot = 2'(sl); upd_x = 10'(x); upd_y = 10'(y); upd_dir = 2'(d); upd_active = act;
    #1;
    while (!upd_ready && tries < 8) begin
      @(negedge vga_clk);
      #1;
      tries++;
    end
    n_checks++;
    if (upd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL write_accept slot=%0d upd_ready=%b exp=1", sl, upd_ready);
    end
    m_shadow[sl] = '{active: act, x: 10'(x), y: 10'(y), dir: dir_e'(d)};
  endtask

  task automatic end_upd();
    @(negedge vga_clk);
    upd_valid = 1'b0;
  endtask

  task automatic do_frame();
    @(negedge vga_clk);
    frame_start = 1'b1;
    blank = 1'b0;
    m_disp = m_shadow;
    @(negedge vga_clk);
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge vga_clk);
    n_checks++;
    if (rom_addr !== 8'h00 || bullet_hit !== 1'b0 || hit_slot !== 2'd0 || upd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got addr=%h hit=%b slot=%0d rdy=%b exp 00/0/0/0",
               rom_addr, bullet_hit, hit_slot, upd_ready);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (upd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset got=%b exp=1", upd_ready);
    end
  endtask

  task automatic test_idle_sweep();
    do_frame();
    for (int y = 0; y < 480; y += 29)
      for (int x = 0; x < 640; x += 37)
        pix(x, y, 1'b1);
  endtask

  task automatic test_single_bullet();
    write_slot(1, 100, 50, 2, 1'b1);
    end_upd();
    do_frame();
    pix(103, 52, 1'b1);
    pix(108, 52, 1'b1);
    for (int x = 95; x < 112; x++) pix(x, 52, 1'b1);
    for (int y = 46; y < 60; y++) pix(101, y, 1'b1);
  endtask

  task automatic test_swap_stall();
    @(negedge vga_clk);
    frame_start = 1'b1;
    blank = 1'b0;
    upd_valid = 1'b1;
    upd_slot = 2'd3; upd_x = 10'd400; upd_y = 10'd300; upd_dir = 2'd1; upd_active = 1'b1;
    m_disp = m_shadow;
    #1;
    n_checks++;
    if (upd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_in_swap got=%b exp=0", upd_ready);
    end
    @(negedge vga_clk);
    frame_start = 1'b0;
    #1;
    n_checks++;
    if (upd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_swap got=%b exp=1", upd_ready);
    end
    m_shadow[3] = '{active: 1'b1, x: 10'd400, y: 10'd300, dir: DIR_RIGHT};
    end_upd();
    for (int x = 398; x < 410; x++) pix(x, 302, 1'b1);
    do_frame();
    for (int x = 398; x < 410; x++) pix(x, 302, 1'b1);
    for (int y = 298; y < 310; y++) pix(405, y, 1'b1);
  endtask

  task automatic test_priority_overlap();
    write_slot(0, 200, 200, 1, 1'b1);
    write_slot(2, 200, 200, 3, 1'b1);
    end_upd();
    do_frame();
    pix(203, 204, 1'b1);
    for (int x = 197; x < 210; x++) pix(x, 200, 1'b1);
    for (int x = 197; x < 210; x++) pix(x, 204, 1'b1);
  endtask

  task automatic test_edge_clip();
    write_slot(3, 636, 476, 0, 1'b1);
    end_upd();
    do_frame();
    for (int y = 474; y < 480; y++)
      for (int x = 632; x < 640; x++)
        pix(x, y, 1'b1);
    pix(0, 476, 1'b1);
    pix(2, 478, 1'b1);
    pix(637, 0, 1'b1);
    pix(0, 0, 1'b1);
    pix(637, 477, 1'b0);
    pix(638, 478, 1'b1);
  endtask

  task automatic test_back_to_back();
    write_slot(2, 300, 100, 0, 1'b1);
    write_slot(2, 320, 100, 0, 1'b1);
    end_upd();
    do_frame();
    for (int x = 298; x < 330; x++) pix(x, 102, 1'b1);
  endtask

  task automatic test_reset_midflight();
    write_slot(0, 10, 10, 0, 1'b1);
    end_upd();
    do_frame();
    pix(12, 12, 1'b1);
    @(negedge vga_clk);
    reset = 1'b1;
    blank = 1'b0;
    aq.delete();
    hq.delete();
    @(negedge vga_clk);
    n_checks++;
    if (bullet_hit !== 1'b0 || rom_addr !== 8'h00 || hit_slot !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_flush got hit=%b addr=%h slot=%0d exp 0/00/0", bullet_hit, rom_addr, hit_slot);
    end
    @(negedge vga_clk);
    n_checks++;
    if (bullet_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flush2 got hit=%b exp=0", bullet_hit);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_shadow[i] = '0;
      m_disp[i] = '0;
    end
    #1;
    n_checks++;
    if (upd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_post_reset got=%b exp=1", upd_ready);
    end
    do_frame();
    for (int x = 8; x < 20; x++) pix(x, 12, 1'b1);
    pix(103, 52, 1'b1);
    pix(203, 204, 1'b1);
    pix(637, 477, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = (i < 64) ? 1'b1 : 1'($urandom_range(0, 1));
    rom_mem[8'h93] = 1'b1;
    rom_mem[8'h63] = 1'b0;
    rom_mem[8'hE3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_shadow[i] = '0;
      m_disp[i] = '0;
    end
    test_reset();
    test_idle_sweep();
    test_single_bullet();
    test_swap_stall();
    test_priority_overlap();
    test_edge_clip();
    test_back_to_back();
    test_reset_midflight();
    repeat (5) pix(0, 0, 1'b0);
    repeat (4) @(negedge vga_clk);
    n_checks++;
    if (aq.size() != 0 || hq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left addr=%0d hit=%0d exp 0/0", aq.size(), hq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bullet_render_sched.md
Name: bullet_render_sched

Overview:
Schedules the single shared bullet sprite ROM, which holds 4 directions of 8x8 1-bpp sprites, among up to NUM_BULLETS on-screen bullets.
Game logic writes bullet slots (position, direction, active) through a valid/ready port into a shadow bank. The shadow bank is copied to the display bank at frame start, so the picture never tears.
For each pixel the block picks the highest-priority bullet covering (DrawX, DrawY), forms the ROM address, and realigns the ROM data into a registered hit/slot output for the pixel mixer.

Parameters:
NUM_BULLETS, 4, number of bullet slots; slot 0 has highest priority.
SPR_DIM, 8, sprite edge in pixels; must be a power of 2.
ROM_AW, 8, ROM address width = 2 (dir) + 2*log2(SPR_DIM).

Ports:
vga_clk  in  1  pixel clock; all logic posedge.
reset  in  1  synchronous, active-high.
frame_start  in  1  one-cycle pulse at start of vertical blank.
upd_valid  in  1  slot update request.
upd_ready  out  1  update accepted when valid & ready.
upd_slot  in  log2(NUM_BULLETS)  slot index.
upd_x  in  10  bullet left-edge X.
upd_y  in  10  bullet top-edge Y.
upd_dir  in  2  0=up 1=right 2=down 3=left.
upd_active  in  1  slot enabled.
DrawX  in  10  current pixel X.
DrawY  in  10  current pixel Y.
blank  in  1  1 = visible region.
rom_addr  out  ROM_AW  address to bullet ROM ({dir, ly, lx}).
rom_q  in  1  ROM data; valid one cycle after rom_addr.
bullet_hit  out  1  opaque bullet pixel.
hit_slot  out  log2(NUM_BULLETS)  slot that produced the hit.

Behaviour:
- Reset:
  - All shadow and display slots inactive, with x/y/dir = 0.
  - upd_ready = 0 while reset is high, 1 on the first cycle after reset.
  - rom_addr = 0, bullet_hit = 0, hit_slot = 0; all pipeline valids cleared.
  - Reset mid-frame discards in-flight pixels; outputs are 0 on the next cycle.
- Update handshake:
  - upd_ready = ~frame_start (outside reset).
  - On valid & ready, shadow[upd_slot] is written at the next edge.
  - Payload is held while valid & ~ready.
  - Writes to the same slot in consecutive cycles: last write wins.
- Bank swap:
  - On frame_start, display <= shadow (all slots at once, one cycle).
  - An update offered in that cycle is stalled by upd_ready = 0 and lands in shadow the next cycle. It appears on screen in the following frame.
- Hit test (stage 0, combinational on inputs), per slot:
  - dx = {1'b0, DrawX} - {1'b0, x}, dy likewise, both 11-bit.
  - Covered when the slot is active, dx[10] = 0, dx < SPR_DIM, dy[10] = 0, dy < SPR_DIM, and blank = 1.
  - No wrap-around: a bullet at x=636 draws only columns 636..639. A pixel left of or above the bullet gives a borrow, which means no hit.
- Priority: the lowest-index covered slot wins. Overlapping bullets show the winner's pixel even if the winner's pixel is transparent (no fall-through).
- Stage 1 (registered, cycle N+1):
  - rom_addr = {dir, dy[2:0], dx[2:0]} of the winner.
  - sel_valid and sel_slot are registered alongside.
  - On a miss, rom_addr = 0 and sel_valid = 0.
- Stage 2: sel_valid and sel_slot are delayed one cycle to align with rom_q.
- Stage 3 (registered, cycle N+3):
  - bullet_hit = sel_valid_d & rom_q.
  - hit_slot = sel_slot_d when bullet_hit, else 0.
- Total latency: DrawX/DrawY sampled in cycle N produce bullet_hit in cycle N+3. Fixed, with no bubbles; one pixel is accepted every cycle.
- The display bank changes only at frame_start, so a pixel never mixes old and new bank data within a frame.

Decomposition:
- Package tank_sprite_pkg holds:
  - SPR_DIM.
  - dir_e enum (DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT).
  - bullet_slot_t struct {active, x[9:0], y[9:0], dir}.
  - The ROM_AW derivation.
- Sub-module bullet_hit_test is a per-slot comparator. Inputs: slot, DrawX, DrawY, blank. Outputs: covered, lx, ly. It is instantiated NUM_BULLETS times via generate.
- The top level holds the banks, the handshake, the priority encoder and the pipeline.

Test Plan:
1. Reset then idle: no updates, sweep a frame -> bullet_hit = 0 throughout; upd_ready = 1 after reset; rom_addr = 0.
2. Slot 1 written (x=100, y=50, dir=2, active), then frame_start -> at DrawX=103, DrawY=52: rom_addr = 8'h93 at N+1; with rom_q=1, bullet_hit=1 and hit_slot=1 at N+3. At DrawX=108: no hit.
3. Update offered in the frame_start cycle -> upd_ready = 0 that cycle, write lands next cycle, bullet is not visible until after the next frame_start.
4. Slots 0 and 2 overlap at (200, 200) with slot 0's rom_q = 0 -> bullet_hit = 0 and slot 2 is not shown; rom_addr uses slot 0's dir.
5. Edge clipping: x=636, y=476 -> hits only for DrawX 636..639 and DrawY 476..479; DrawX=0 gives no hit (no wrap); blank=0 in the box gives no hit.
6. Reset asserted while a hit is in flight -> bullet_hit = 0 on the next cycle; all slots are inactive after reset.
